// File: rtl/vid_phy_txos_pkg.sv
// vid_phy_txos_pkg: shared constants, ratio clamp and level type for the TX oversampler
package vid_phy_txos_pkg;

    localparam int SYM_W     = 10;
    localparam int RATIO_MIN = 1;

    typedef logic [6:0] level_t;

    function automatic int calc_buf_w(input int w, input int rmax);
        return ((2 * w + SYM_W * rmax - w + 7) / 8) * 8;
    endfunction

    localparam int BUF_W = calc_buf_w(40, 5);

    function automatic logic [2:0] clamp_ratio(input logic [2:0] r, input int rmax);
        return (r == 3'd0 || int'(r) > rmax) ? 3'(RATIO_MIN) : r;
    endfunction

endpackage

// File: rtl/vid_phy_tx_oversampler_expand.sv
// vid_phy_tx_oversampler_expand: replicates each symbol bit ratio_i times, LSB first, packed from bit 0
module vid_phy_txos_expand
    import vid_phy_txos_pkg::*;
#(
    parameter int RATIO_MAX = 5
) (
    input  logic [SYM_W-1:0]           sym_i,
    input  logic [2:0]                 ratio_i,
    output logic [SYM_W*RATIO_MAX-1:0] samp_o
);

    localparam int SW = SYM_W * RATIO_MAX;

    logic [SW-1:0] rep [8];

    for (genvar r = 0; r < 8; r++) begin : g_r
        for (genvar j = 0; j < SW; j++) begin : g_j
            if (r >= RATIO_MIN && r <= RATIO_MAX && j < SYM_W * r) begin : g_on
                assign rep[r][j] = sym_i[j / r];
            end else begin : g_off
                assign rep[r][j] = 1'b0;
            end
        end
    end

    assign samp_o = rep[ratio_i];

endmodule

// File: rtl/vid_phy_tx_oversampler.sv
// vid_phy_tx_oversampler: bit-replicating TX oversampler with sample buffer; optional UFLOW_CNT_OUT via VID_PHY_TXOS_UFLOW_CNT_EN
module vid_phy_tx_oversampler
    import vid_phy_txos_pkg::*;
#(
    parameter int WIDTH_OUT = 40,
    parameter int RATIO_MAX = 5
) (
    input  logic                 TXOS_CLK_IN,
    input  logic                 TXOS_RST_IN,
    input  logic                 TXOS_EN_IN,
    input  logic [2:0]           TXOS_RATIO_IN,
    input  logic [WIDTH_OUT-1:0] DAT_IN,
    input  logic                 DAT_VLD_IN,
    output logic                 DAT_RDY_OUT,
    output logic [WIDTH_OUT-1:0] TX_DATA_OUT,
    output logic                 UFLOW_OUT,
    input  logic                 UFLOW_CLR_IN,
`ifdef VID_PHY_TXOS_UFLOW_CNT_EN
    output logic [15:0]          UFLOW_CNT_OUT,
`endif
    output logic [6:0]           LEVEL_OUT
);

    localparam int     BW    = calc_buf_w(WIDTH_OUT, RATIO_MAX);
    localparam int     SW    = SYM_W * RATIO_MAX;
    localparam level_t W_L   = level_t'(WIDTH_OUT);
    localparam level_t RDY_L = level_t'(WIDTH_OUT + SYM_W);

    logic                 en_q, en2_q, run_q, uflow_q;
    logic [2:0]           ratio_q, ratio_d;
    level_t               level_q, level_d, rem_lvl, n_samp;
    logic [BW-1:0]        buf_q, buf_d, rem_buf, ins;
    logic [WIDTH_OUT-1:0] tx_q, tx_d;
    logic [SW-1:0]        samp;
    logic                 en_rise, push, pop, uf;

    vid_phy_txos_expand #(.RATIO_MAX(RATIO_MAX)) u_expand (
        .sym_i   (DAT_IN[SYM_W-1:0]),
        .ratio_i (ratio_d),
        .samp_o  (samp)
    );

    // Ratio is taken from the port only on the enable edge so that edge's word already uses it
    assign en_rise = TXOS_EN_IN & ~en_q;
    assign ratio_d = en_rise ? clamp_ratio(TXOS_RATIO_IN, RATIO_MAX) : ratio_q;
    assign n_samp  = level_t'(SYM_W) * level_t'(ratio_d);

    // Ready depends only on registered state; run_q keeps it low until the first clock out of reset
    assign DAT_RDY_OUT = run_q & (~TXOS_EN_IN | (level_q < RDY_L));
    assign push        = TXOS_EN_IN & DAT_VLD_IN & DAT_RDY_OUT;
    assign pop         = TXOS_EN_IN & (level_q >= W_L);
    assign uf          = TXOS_EN_IN & ~pop & en_q & en2_q;

    // Pop first, then append the expanded word just above the surviving samples
    assign rem_buf = pop ? buf_q >> WIDTH_OUT : buf_q;
    assign rem_lvl = pop ? level_q - W_L : level_q;
    assign ins     = {{(BW - SW){1'b0}}, samp} << rem_lvl;

    // Next buffer, level and output word; on underflow the last sent bit is held to avoid false edges
    always_comb begin
        buf_d   = TXOS_EN_IN ? (rem_buf | (push ? ins : '0)) : '0;
        level_d = TXOS_EN_IN ? rem_lvl + (push ? n_samp : level_t'(0)) : level_t'(0);
        tx_d    = ~TXOS_EN_IN ? DAT_IN
                : pop ? buf_q[WIDTH_OUT-1:0]
                : {WIDTH_OUT{tx_q[WIDTH_OUT-1]}};
    end

    // State registers; underflow set takes priority over clear
    always_ff @(posedge TXOS_CLK_IN or posedge TXOS_RST_IN) begin
        if (TXOS_RST_IN) begin
            en_q    <= 1'b0;
            en2_q   <= 1'b0;
            run_q   <= 1'b0;
            ratio_q <= 3'(RATIO_MIN);
            level_q <= '0;
            buf_q   <= '0;
            tx_q    <= '0;
            uflow_q <= 1'b0;
        end else begin
            en_q    <= TXOS_EN_IN;
            en2_q   <= en_q;
            run_q   <= 1'b1;
            ratio_q <= ratio_d;
            level_q <= level_d;
            buf_q   <= buf_d;
            tx_q    <= tx_d;
            uflow_q <= uf | (uflow_q & ~UFLOW_CLR_IN);
        end
    end

`ifdef VID_PHY_TXOS_UFLOW_CNT_EN
    logic [15:0] cnt_q;

    // Saturating count of underflow cycles
    always_ff @(posedge TXOS_CLK_IN or posedge TXOS_RST_IN) begin
        if (TXOS_RST_IN) cnt_q <= '0;
        else cnt_q <= UFLOW_CLR_IN ? '0 : (uf && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    assign UFLOW_CNT_OUT = cnt_q;
`endif

    assign TX_DATA_OUT = tx_q;
    assign UFLOW_OUT   = uflow_q;
    assign LEVEL_OUT   = level_q;

endmodule

// File: tb/tb_vid_phy_tx_oversampler.sv
// tb_vid_phy_tx_oversampler: directed self-checking bench with a bit-queue reference for streaming
module tb_vid_phy_tx_oversampler;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, vld = 1'b0, clr = 1'b0;
    logic [2:0]  ratio = 3'd1;
    logic [39:0] dat = '0;
    logic        rdy, uf;
    logic [39:0] tx;
    logic [6:0]  lvl;
    int          n_cmp = 0, n_bad = 0;
`ifdef VID_PHY_TXOS_UFLOW_CNT_EN
    logic [15:0] cnt;
`endif

    always #5 clk = ~clk;

    vid_phy_tx_oversampler dut (
        .TXOS_CLK_IN   (clk),
        .TXOS_RST_IN   (rst),
        .TXOS_EN_IN    (en),
        .TXOS_RATIO_IN (ratio),
        .DAT_IN        (dat),
        .DAT_VLD_IN    (vld),
        .DAT_RDY_OUT   (rdy),
        .TX_DATA_OUT   (tx),
        .UFLOW_OUT     (uf),
        .UFLOW_CLR_IN  (clr),
`ifdef VID_PHY_TXOS_UFLOW_CNT_EN
        .UFLOW_CNT_OUT (cnt),
`endif
        .LEVEL_OUT     (lvl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (tx !== 40'h0) begin n_bad++; $display("FAIL reset_tx got %h want 0", tx); end
        n_cmp++; if (uf !== 1'b0) begin n_bad++; $display("FAIL reset_uf got %b want 0", uf); end
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", rdy); end
        n_cmp++; if (lvl !== 7'd0) begin n_bad++; $display("FAIL reset_lvl got %0d want 0", lvl); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        en = 1'b0; dat = 40'h12345ABCDE;
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL bypass_rdy got %b want 1", rdy); end
        tick();
        n_cmp++; if (tx !== 40'h12345ABCDE) begin n_bad++; $display("FAIL bypass_tx got %h want 12345abcde", tx); end
        n_cmp++; if (lvl !== 7'd0) begin n_bad++; $display("FAIL bypass_lvl got %0d want 0", lvl); end
    endtask

    task automatic test_bit_order();
        en = 1'b1; ratio = 3'd4; vld = 1'b1; dat = 40'h3A5;
        tick();
        vld = 1'b0;
        n_cmp++; if (lvl !== 7'd40) begin n_bad++; $display("FAIL bo_lvl got %0d want 40", lvl); end
        n_cmp++; if (tx !== 40'h0) begin n_bad++; $display("FAIL bo_fill_tx got %h want 0", tx); end
        n_cmp++; if (uf !== 1'b0) begin n_bad++; $display("FAIL bo_fill_uf got %b want 0", uf); end
        tick();
        n_cmp++; if (tx !== 40'hFFF0F00F0F) begin n_bad++; $display("FAIL bo_tx got %h want fff0f00f0f", tx); end
        n_cmp++; if (lvl !== 7'd0) begin n_bad++; $display("FAIL bo_lvl0 got %0d want 0", lvl); end
        tick();
        n_cmp++; if (tx !== 40'hFFFFFFFFFF) begin n_bad++; $display("FAIL bo_run_tx got %h want ffffffffff", tx); end
        n_cmp++; if (uf !== 1'b1) begin n_bad++; $display("FAIL bo_uf got %b want 1", uf); end
        clr = 1'b1;
        tick();
        n_cmp++; if (uf !== 1'b1) begin n_bad++; $display("FAIL set_beats_clr got %b want 1", uf); end
        en = 1'b0;
        tick();
        clr = 1'b0;
        n_cmp++; if (uf !== 1'b0) begin n_bad++; $display("FAIL clr got %b want 0", uf); end
    endtask

    task automatic test_ratio_latch();
        en = 1'b1; ratio = 3'd4; vld = 1'b0;
        tick();
        ratio = 3'd2; vld = 1'b1; dat = 40'h001;
        tick();
        vld = 1'b0;
        n_cmp++; if (lvl !== 7'd40) begin n_bad++; $display("FAIL latch_lvl got %0d want 40", lvl); end
        tick();
        n_cmp++; if (tx !== 40'h000000000F) begin n_bad++; $display("FAIL latch_tx got %h want 000000000f", tx); end
        en = 1'b0;
        tick();
        en = 1'b1; ratio = 3'd2; vld = 1'b1; dat = 40'h001;
        tick();
        n_cmp++; if (lvl !== 7'd20) begin n_bad++; $display("FAIL relatch_lvl got %0d want 20", lvl); end
        dat = 40'h3FF;
        tick();
        vld = 1'b0;
        n_cmp++; if (lvl !== 7'd40) begin n_bad++; $display("FAIL r2_lvl got %0d want 40", lvl); end
        tick();
        n_cmp++; if (tx !== 40'hFFFFF00003) begin n_bad++; $display("FAIL r2_tx got %h want fffff00003", tx); end
        n_cmp++; if (lvl !== 7'd0) begin n_bad++; $display("FAIL r2_lvl0 got %0d want 0", lvl); end
    endtask

    task automatic test_stream(input logic [2:0] raw, input int n, input bit alt);
        bit          q[$];
        int          r, idx, max_lvl;
        logic [39:0] exp_tx;
        logic [9:0]  w;
        logic        exp_uf, pop, push;
        r = (raw == 3'd0 || raw > 3'd5) ? 1 : int'(raw);
        en = 1'b0; vld = 1'b0; dat = '0; clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_tx = '0; exp_uf = 1'b0; idx = 0; max_lvl = 0;
        en = 1'b1; ratio = raw; vld = 1'b1;
        for (int c = 0; c < n; c++) begin
            w = alt ? (idx[0] ? 10'h2AA : 10'h155) : 10'(idx * 37 + 5);
            dat = {30'd0, w};
            n_cmp++; if (rdy !== (q.size() < 50)) begin n_bad++; $display("FAIL st_rdy r=%0d c=%0d got %b want %b", r, c, rdy, q.size() < 50); end
            n_cmp++; if (lvl !== 7'(q.size())) begin n_bad++; $display("FAIL st_lvl r=%0d c=%0d got %0d want %0d", r, c, lvl, q.size()); end
            if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
            pop = q.size() >= 40;
            push = q.size() < 50;
            if (pop) for (int i = 0; i < 40; i++) exp_tx[i] = q.pop_front();
            else exp_tx = {40{exp_tx[39]}};
            if (push) begin
                for (int k = 0; k < 10; k++) for (int j = 0; j < r; j++) q.push_back(w[k]);
                idx++;
            end
            if (!pop && c >= 2) exp_uf = 1'b1;
            tick();
            n_cmp++; if (tx !== exp_tx) begin n_bad++; $display("FAIL st_tx r=%0d c=%0d got %h want %h", r, c, tx, exp_tx); end
            n_cmp++; if (uf !== exp_uf) begin n_bad++; $display("FAIL st_uf r=%0d c=%0d got %b want %b", r, c, uf, exp_uf); end
        end
        n_cmp++; if (max_lvl > 96) begin n_bad++; $display("FAIL st_max_lvl r=%0d got %0d want <=96", r, max_lvl); end
        vld = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b0; vld = 1'b0;
        tick();
        en = 1'b1; ratio = 3'd4; vld = 1'b1; dat = 40'h3A5;
        tick();
        tick();
        n_cmp++; if (tx !== 40'hFFF0F00F0F) begin n_bad++; $display("FAIL mid_pre_tx got %h want fff0f00f0f", tx); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 40'h0) begin n_bad++; $display("FAIL mid_tx got %h want 0", tx); end
        n_cmp++; if (lvl !== 7'd0) begin n_bad++; $display("FAIL mid_lvl got %0d want 0", lvl); end
        n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rdy got %b want 0", rdy); end
        n_cmp++; if (uf !== 1'b0) begin n_bad++; $display("FAIL mid_uf got %b want 0", uf); end
        rst = 1'b0; en = 1'b0; vld = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_bit_order();
        test_ratio_latch();
        test_stream(3'd4, 30, 1'b0);
        test_stream(3'd3, 60, 1'b0);
        test_stream(3'd5, 60, 1'b1);
        test_stream(3'd0, 24, 1'b0);
        test_stream(3'd7, 12, 1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vid_phy_tx_oversampler.md
Name: vid_phy_tx_oversampler

Overview:
- TX-side counterpart of the NIDRU receive path.
- Accepts 10-bit symbol words from the link layer on a ready/valid handshake.
- Replicates each bit OS_RATIO times (LSB first) and packs the samples into a constant WIDTH_OUT-bit word every clock for the transceiver, so low line rates can use a GT running above its minimum rate.
- When disabled, the block is a registered pass-through of the full-width input word.

Parameters:
- WIDTH_OUT, 40, transceiver word width in samples; legal values 20 and 40.
- RATIO_MAX, 5, largest supported oversampling ratio; sizes the sample buffer.

Ports:
- TXOS_CLK_IN  in  1  transceiver TX user clock; single clock domain.
- TXOS_RST_IN  in  1  reset, asynchronous, active-high.
- TXOS_EN_IN  in  1  1 = oversampling active, 0 = bypass.
- TXOS_RATIO_IN  in  3  oversampling ratio, 1..RATIO_MAX; 0 and values above RATIO_MAX are treated as 1.
- DAT_IN  in  WIDTH_OUT  input data; only [9:0] are used when enabled.
- DAT_VLD_IN  in  1  input valid.
- DAT_RDY_OUT  out  1  input ready.
- TX_DATA_OUT  out  WIDTH_OUT  samples to the transceiver; bit 0 is transmitted first.
- UFLOW_OUT  out  1  sticky underflow flag.
- UFLOW_CLR_IN  in  1  clears UFLOW_OUT.
- LEVEL_OUT  out  7  current sample-buffer fill level, for debug.

Behaviour:
- Reset:
  - buffer level 0; TX_DATA_OUT all 0; UFLOW_OUT 0; DAT_RDY_OUT 0; latched ratio 1.
  - Reset asserted mid-operation discards all buffered samples immediately.
- Ratio latch:
  - TXOS_RATIO_IN is captured on the cycle TXOS_EN_IN goes 0→1.
  - Changes while enabled are ignored until the next enable edge.
- Bypass (TXOS_EN_IN=0):
  - DAT_RDY_OUT=1.
  - TX_DATA_OUT <= DAT_IN every cycle; latency 1.
  - Buffer is flushed to level 0.
- Sample buffer (enabled):
  - Buffer width BUF_W = 2*WIDTH_OUT + 10*RATIO_MAX − WIDTH_OUT rounded up to a multiple of 8; 96 at defaults. Level counts valid samples.
  - Expansion: an accepted word contributes 10*R samples. Input bit k becomes samples k*R .. k*R+R−1 and is appended above the existing samples.
- Pop:
  - If level ≥ WIDTH_OUT at the clock edge, the lowest WIDTH_OUT samples go to TX_DATA_OUT (registered, 1 cycle) and the buffer shifts down by WIDTH_OUT.
- Ready: DAT_RDY_OUT = (level < WIDTH_OUT + 10), decoded from the registered level. No combinational path from DAT_VLD_IN.
- Push: on DAT_VLD_IN & DAT_RDY_OUT.
- Simultaneous push and pop:
  - The pop is applied first; new samples append after the remaining ones.
  - level_next = level − pop*WIDTH_OUT + push*10R. The bound level_next ≤ BUF_W is guaranteed by the ready rule.
- Underflow:
  - Enabled and level < WIDTH_OUT → no pop. TX_DATA_OUT repeats its last sample bit across all WIDTH_OUT bits (run extension, no false edges). UFLOW_OUT is set.
  - The first two cycles after enable are fill time and do not set UFLOW_OUT.
- UFLOW_CLR_IN:
  - Clears UFLOW_OUT next cycle.
  - Set wins over clear when both occur in the same cycle.
- Throughput: R=4, WIDTH_OUT=40 consumes exactly one word per clock. R=3 consumes 4 words per 3 clocks. R=5 consumes 4 words per 5 clocks.
- Latency: a pushed word first appears on TX_DATA_OUT 1 cycle after the level reaches WIDTH_OUT.

Optional Feature:
- Macro: VID_PHY_TXOS_UFLOW_CNT_EN.
- Defined:
  - Adds output UFLOW_CNT_OUT[15:0], counting underflow cycles.
  - Saturates at 16'hFFFF; cleared by UFLOW_CLR_IN and by reset.
- Undefined: port absent; no counter logic.

Decomposition:
- Package vid_phy_txos_pkg holds:
  - localparams BUF_W, SYM_W=10, RATIO_MIN=1.
  - function clamp_ratio().
  - typedef for the level counter.
- Sub-module vid_phy_txos_expand: combinational 10-bit → 10*RATIO_MAX sample replicator, driven by the latched ratio, output left-aligned at bit 0.
- The top module holds the buffer, level arithmetic, handshake and flags.

Test Plan:
- Bit order at R=4, WIDTH_OUT=40: single push DAT_IN=10'h3A5 → TX_DATA_OUT = 40'hFFF0F00F0F one cycle after acceptance; then underflow words all 1s and UFLOW_OUT=1.
- Bypass: EN=0, DAT_IN=40'h12345ABCDE → same value on TX_DATA_OUT next cycle; DAT_RDY_OUT=1.
- Rate match: R=3, DAT_VLD_IN held 1 for 300 cycles → exactly 400±1 words accepted, UFLOW_OUT stays 0 after fill, every 3-sample group is uniform.
- R=5 backpressure with alternating 10'h155/10'h2AA:
  - DAT_RDY_OUT deasserts when level ≥ 50.
  - Level never exceeds 96; output is a continuous 5-sample alternating pattern.
- Reset and clear:
  - TXOS_RST_IN pulsed mid-stream → all outputs 0 immediately, level 0.
  - UFLOW_CLR_IN coinciding with an underflow cycle → UFLOW_OUT remains 1.
- Ratio latch and counter:
  - TXOS_RATIO_IN changed 4→2 while enabled → replication stays 4 until EN toggles.
  - With VID_PHY_TXOS_UFLOW_CNT_EN, 70000 underflow cycles → UFLOW_CNT_OUT=16'hFFFF.
